// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared widths and the buffered long-latency result entry type
//               for the writeback port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  // One buffered long-latency result: destination register and data.
  typedef struct packed {
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
  } ll_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of the pipeline-facing signals of the writeback port
//               arbiter.
//   W stage    : RegWriteW, RdW, ResultW            (pipeline -> arbiter)
//   LL unit    : LLIssue, LLIssueRd, LLValid, LLRd,
//                LLResult                           (pipeline -> arbiter)
//                LLReady                            (arbiter -> pipeline)
//   Hazard     : Rs1D, Rs2D                         (pipeline -> arbiter)
//                BusyRs1, BusyRs2, BubbleReq        (arbiter -> pipeline)
//   Reg file   : RfWE, RfA3, RfWD                   (arbiter -> pipeline)
//   master = pipeline side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic            RegWriteW;
  logic [REGW-1:0] RdW;
  logic [XLEN-1:0] ResultW;
  logic            LLIssue;
  logic [REGW-1:0] LLIssueRd;
  logic            LLValid;
  logic [REGW-1:0] LLRd;
  logic [XLEN-1:0] LLResult;
  logic            LLReady;
  logic [REGW-1:0] Rs1D;
  logic [REGW-1:0] Rs2D;
  logic            BusyRs1;
  logic            BusyRs2;
  logic            BubbleReq;
  logic            RfWE;
  logic [REGW-1:0] RfA3;
  logic [XLEN-1:0] RfWD;

  modport master (
    output RegWriteW, RdW, ResultW,
    output LLIssue, LLIssueRd, LLValid, LLRd, LLResult,
    output Rs1D, Rs2D,
    input  LLReady, BusyRs1, BusyRs2, BubbleReq,
    input  RfWE, RfA3, RfWD
  );

  modport slave (
    input  RegWriteW, RdW, ResultW,
    input  LLIssue, LLIssueRd, LLValid, LLRd, LLResult,
    input  Rs1D, Rs2D,
    output LLReady, BusyRs1, BusyRs2, BubbleReq,
    output RfWE, RfA3, RfWD
  );

endinterface : wb_port_arbiter_if
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO of ll_entry_t. Pointers carry one extra wrap
//               bit so count = wr_ptr - rd_ptr distinguishes full from empty.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push       : enqueue push_data (ignored when full)
//   push_data  : entry to enqueue
//   pop        : dequeue head (ignored when empty)
//   head       : oldest entry
//   full/empty : registered occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic      clk,
  input  wire logic      reset,
  input  wire logic      push,
  input  wire ll_entry_t push_data,
  input  wire logic      pop,
  output ll_entry_t      head,
  output logic           full,
  output logic           empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  ll_entry_t   mem_q [DEPTH];
  ll_entry_t   mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] w_count;
  logic        w_push_ok;
  logic        w_pop_ok;

  // Unsigned subtraction with the wrap bit yields the occupancy across wrap.
  assign w_count   = wr_ptr_q - rd_ptr_q;
  assign full      = (w_count == c_depth);
  assign empty     = (w_count == '0);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (w_pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read while the pointers say so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Arbitrates the single register-file write port. W-stage
//               writes win unconditionally; buffered long-latency results
//               drain in W-idle cycles. Keeps a busy scoreboard for D-stage
//               hazard detection and a starvation counter that requests a
//               pipeline bubble when buffered results wait too long.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : wb_port_arbiter_if.slave (W stage, LL unit, hazard, reg file)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  wb_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);

  logic             w_w_active;
  logic             w_drain;
  logic             w_accept;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  ll_entry_t        w_head;
  ll_entry_t        w_push_data;

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Nothing is written to the register file while reset is asserted.
  assign w_w_active = !reset && bus.RegWriteW && (bus.RdW != '0);
  assign w_drain    = !reset && !w_w_active && !w_empty;

  // Ready reflects the registered occupancy only; a same-cycle pop does not
  // open a slot early.
  assign bus.LLReady = !w_full && !reset;
  assign w_accept    = bus.LLValid && bus.LLReady;
  // Results for x0 are acknowledged but never occupy a buffer slot.
  assign w_push      = w_accept && (bus.LLRd != '0);
  assign w_push_data = '{rd: bus.LLRd, data: bus.LLResult};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_drain),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    bus.RfWE = 1'b0;
    bus.RfA3 = '0;
    bus.RfWD = '0;
    if (w_w_active) begin
      bus.RfWE = 1'b1;
      bus.RfA3 = bus.RdW;
      bus.RfWD = bus.ResultW;
    end else if (w_drain) begin
      bus.RfWE = 1'b1;
      bus.RfA3 = w_head.rd;
      bus.RfWD = w_head.data;
    end
  end

  // Scoreboard: clear on drain first so a same-cycle issue to the same
  // register leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (w_drain) begin
      busy_d[w_head.rd] = 1'b0;
    end
    if (bus.LLIssue && (bus.LLIssueRd != '0)) begin
      busy_d[bus.LLIssueRd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Starvation counter counts cycles the buffer is non-empty but blocked.
  always_comb begin
    cnt_d = cnt_q;
    if (w_empty || w_drain) begin
      cnt_d = '0;
    end else if (cnt_q != c_limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.BusyRs1   = !reset && busy_q[bus.Rs1D];
  assign bus.BusyRs2   = !reset && busy_q[bus.Rs2D];
  assign bus.BubbleReq = !reset && (cnt_q == c_limit);

endmodule : wb_port_arbiter
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed self-checking bench for wb_port_arbiter
//               (DEPTH=2, STARVE_LIMIT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 time unit later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.RegWriteW = 1'b0;
    bus.RdW       = '0;
    bus.ResultW   = '0;
    bus.LLIssue   = 1'b0;
    bus.LLIssueRd = '0;
    bus.LLValid   = 1'b0;
    bus.LLRd      = '0;
    bus.LLResult  = '0;
    bus.Rs1D      = '0;
    bus.Rs2D      = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    bus.RegWriteW = 1'b1; bus.RdW = 5'd5; bus.ResultW = 32'h1;
    tick();
    n_cmp++; if (bus.RfWE !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0h want 0", bus.RfWE); end
    n_cmp++; if (bus.LLReady !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %0h want 0", bus.LLReady); end
    n_cmp++; if (bus.BubbleReq !== 1'b0) begin n_err++; $display("FAIL rst_bubble: got %0h want 0", bus.BubbleReq); end
    n_cmp++; if (bus.BusyRs1 !== 1'b0) begin n_err++; $display("FAIL rst_busy1: got %0h want 0", bus.BusyRs1); end
    tick();
    reset = 1'b0;
    clear_inputs();
    settle();
    n_cmp++; if (bus.LLReady !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %0h want 1", bus.LLReady); end
    n_cmp++; if (bus.RfWE !== 1'b0) begin n_err++; $display("FAIL post_rst_we: got %0h want 0", bus.RfWE); end
  endtask

  task automatic test_w_traffic();
    tick();
    bus.RegWriteW = 1'b1; bus.RdW = 5'd5; bus.ResultW = 32'hDEADBEEF;
    settle();
    n_cmp++; if (bus.RfWE !== 1'b1) begin n_err++; $display("FAIL w_we: got %0h want 1", bus.RfWE); end
    n_cmp++; if (bus.RfA3 !== 5'd5) begin n_err++; $display("FAIL w_a3: got %0d want 5", bus.RfA3); end
    n_cmp++; if (bus.RfWD !== 32'hDEADBEEF) begin n_err++; $display("FAIL w_wd: got %h want deadbeef", bus.RfWD); end
    bus.RdW = 5'd0;
    settle();
    n_cmp++; if (bus.RfWE !== 1'b0) begin n_err++; $display("FAIL w_x0_we: got %0h want 0", bus.RfWE); end
    n_cmp++; if (bus.RfWD !== 32'h0) begin n_err++; $display("FAIL w_x0_wd: got %h want 0", bus.RfWD); end
    clear_inputs();
  endtask

  task automatic test_idle_drain();
    tick();
    bus.LLIssue = 1'b1; bus.LLIssueRd = 5'd7; bus.Rs1D = 5'd7;
    settle();
    n_cmp++; if (bus.BusyRs1 !== 1'b0) begin n_err++; $display("FAIL drain_busy_issue: got %0h want 0", bus.BusyRs1); end
    tick();
    bus.LLIssue = 1'b0;
    bus.LLValid = 1'b1; bus.LLRd = 5'd7; bus.LLResult = 32'h1234;
    settle();
    n_cmp++; if (bus.BusyRs1 !== 1'b1) begin n_err++; $display("FAIL drain_busy_n1: got %0h want 1", bus.BusyRs1); end
    n_cmp++; if (bus.RfWE !== 1'b0) begin n_err++; $display("FAIL drain_nobypass: got %0h want 0", bus.RfWE); end
    tick();
    bus.LLValid = 1'b0;
    settle();
    n_cmp++; if (bus.RfWE !== 1'b1) begin n_err++; $display("FAIL drain_we: got %0h want 1", bus.RfWE); end
    n_cmp++; if (bus.RfA3 !== 5'd7) begin n_err++; $display("FAIL drain_a3: got %0d want 7", bus.RfA3); end
    n_cmp++; if (bus.RfWD !== 32'h1234) begin n_err++; $display("FAIL drain_wd: got %h want 1234", bus.RfWD); end
    n_cmp++; if (bus.BusyRs1 !== 1'b1) begin n_err++; $display("FAIL drain_busy_cyc: got %0h want 1", bus.BusyRs1); end
    tick();
    n_cmp++; if (bus.RfWE !== 1'b0) begin n_err++; $display("FAIL drain_after_we: got %0h want 0", bus.RfWE); end
    n_cmp++; if (bus.BusyRs1 !== 1'b0) begin n_err++; $display("FAIL drain_after_busy: got %0h want 0", bus.BusyRs1); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    tick();
    bus.RegWriteW = 1'b1; bus.RdW = 5'd1; bus.ResultW = 32'h11;
    bus.LLValid = 1'b1; bus.LLRd = 5'd10; bus.LLResult = 32'hA0;
    settle();
    n_cmp++; if (bus.LLReady !== 1'b1) begin n_err++; $display("FAIL full_ready0: got %0h want 1", bus.LLReady); end
    tick();
    bus.LLRd = 5'd11; bus.LLResult = 32'hA1;
    settle();
    n_cmp++; if (bus.LLReady !== 1'b1) begin n_err++; $display("FAIL full_ready1: got %0h want 1", bus.LLReady); end
    tick();
    bus.LLRd = 5'd12; bus.LLResult = 32'hA2;
    settle();
    n_cmp++; if (bus.LLReady !== 1'b0) begin n_err++; $display("FAIL full_ready2: got %0h want 0", bus.LLReady); end
    n_cmp++; if (bus.RfA3 !== 5'd1) begin n_err++; $display("FAIL full_wprio: got %0d want 1", bus.RfA3); end
    tick();
    bus.RegWriteW = 1'b0;
    settle();
    n_cmp++; if (bus.RfA3 !== 5'd10 || bus.RfWD !== 32'hA0 || bus.RfWE !== 1'b1) begin
      n_err++; $display("FAIL full_pop0: got a3=%0d wd=%h we=%0h want a3=10 wd=a0 we=1", bus.RfA3, bus.RfWD, bus.RfWE); end
    n_cmp++; if (bus.LLReady !== 1'b0) begin n_err++; $display("FAIL full_ready_pop: got %0h want 0", bus.LLReady); end
    tick();
    settle();
    n_cmp++; if (bus.LLReady !== 1'b1) begin n_err++; $display("FAIL full_ready_ret: got %0h want 1", bus.LLReady); end
    n_cmp++; if (bus.RfA3 !== 5'd11 || bus.RfWD !== 32'hA1) begin
      n_err++; $display("FAIL full_pop1: got a3=%0d wd=%h want a3=11 wd=a1", bus.RfA3, bus.RfWD); end
    tick();
    bus.LLValid = 1'b0;
    settle();
    n_cmp++; if (bus.RfA3 !== 5'd12 || bus.RfWD !== 32'hA2) begin
      n_err++; $display("FAIL full_pop2: got a3=%0d wd=%h want a3=12 wd=a2", bus.RfA3, bus.RfWD); end
    tick();
    n_cmp++; if (bus.RfWE !== 1'b0) begin n_err++; $display("FAIL full_empty_we: got %0h want 0", bus.RfWE); end
    clear_inputs();
  endtask

  task automatic test_starvation();
    logic exp;
    tick();
    bus.RegWriteW = 1'b1; bus.RdW = 5'd2; bus.ResultW = 32'h22;
    bus.LLValid = 1'b1; bus.LLRd = 5'd20; bus.LLResult = 32'h55;
    tick();
    bus.LLValid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      settle();
      exp = (i >= 5);
      n_cmp++; if (bus.BubbleReq !== exp) begin n_err++; $display("FAIL starve_c%0d: got %0h want %0h", i, bus.BubbleReq, exp); end
      tick();
    end
    bus.RegWriteW = 1'b0;
    settle();
    n_cmp++; if (bus.RfWE !== 1'b1 || bus.RfA3 !== 5'd20 || bus.RfWD !== 32'h55) begin
      n_err++; $display("FAIL starve_drain: got we=%0h a3=%0d wd=%h want we=1 a3=20 wd=55", bus.RfWE, bus.RfA3, bus.RfWD); end
    n_cmp++; if (bus.BubbleReq !== 1'b1) begin n_err++; $display("FAIL starve_hold: got %0h want 1", bus.BubbleReq); end
    tick();
    n_cmp++; if (bus.BubbleReq !== 1'b0) begin n_err++; $display("FAIL starve_clr: got %0h want 0", bus.BubbleReq); end
    n_cmp++; if (bus.RfWE !== 1'b0) begin n_err++; $display("FAIL starve_empty: got %0h want 0", bus.RfWE); end
    clear_inputs();
  endtask

  task automatic test_collision();
    tick();
    bus.LLIssue = 1'b1; bus.LLIssueRd = 5'd9; bus.Rs2D = 5'd9;
    tick();
    bus.LLIssue = 1'b0;
    bus.LLValid = 1'b1; bus.LLRd = 5'd9; bus.LLResult = 32'h99;
    tick();
    bus.LLValid = 1'b0;
    bus.LLIssue = 1'b1; bus.LLIssueRd = 5'd9;
    settle();
    n_cmp++; if (bus.RfWE !== 1'b1 || bus.RfA3 !== 5'd9) begin
      n_err++; $display("FAIL coll_drain: got we=%0h a3=%0d want we=1 a3=9", bus.RfWE, bus.RfA3); end
    tick();
    bus.LLIssue = 1'b0;
    settle();
    n_cmp++; if (bus.BusyRs2 !== 1'b1) begin n_err++; $display("FAIL coll_busy: got %0h want 1", bus.BusyRs2); end
    bus.LLValid = 1'b1; bus.LLRd = 5'd0; bus.LLResult = 32'hFF;
    settle();
    n_cmp++; if (bus.LLReady !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %0h want 1", bus.LLReady); end
    tick();
    bus.LLValid = 1'b0;
    settle();
    n_cmp++; if (bus.RfWE !== 1'b0) begin n_err++; $display("FAIL x0_we: got %0h want 0", bus.RfWE); end
    n_cmp++; if (bus.BusyRs2 !== 1'b1) begin n_err++; $display("FAIL x0_busy: got %0h want 1", bus.BusyRs2); end
    clear_inputs();
    bus.Rs2D = 5'd9;
  endtask

  task automatic test_reset_midop();
    tick();
    bus.RegWriteW = 1'b1; bus.RdW = 5'd1; bus.ResultW = 32'h1;
    bus.LLIssue = 1'b1; bus.LLIssueRd = 5'd3; bus.Rs1D = 5'd3;
    tick();
    bus.LLIssue = 1'b0;
    bus.LLValid = 1'b1; bus.LLRd = 5'd3; bus.LLResult = 32'h33;
    tick();
    bus.LLRd = 5'd4; bus.LLResult = 32'h44;
    tick();
    bus.LLValid = 1'b0;
    settle();
    n_cmp++; if (bus.BusyRs1 !== 1'b1) begin n_err++; $display("FAIL mid_busy_pre: got %0h want 1", bus.BusyRs1); end
    n_cmp++; if (bus.LLReady !== 1'b0) begin n_err++; $display("FAIL mid_full_pre: got %0h want 0", bus.LLReady); end
    bus.RegWriteW = 1'b0;
    reset = 1'b1;
    settle();
    n_cmp++; if (bus.RfWE !== 1'b0) begin n_err++; $display("FAIL mid_rst_we: got %0h want 0", bus.RfWE); end
    n_cmp++; if (bus.LLReady !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %0h want 0", bus.LLReady); end
    tick();
    reset = 1'b0;
    settle();
    n_cmp++; if (bus.RfWE !== 1'b0) begin n_err++; $display("FAIL mid_post_we: got %0h want 0", bus.RfWE); end
    n_cmp++; if (bus.BusyRs1 !== 1'b0 || bus.BusyRs2 !== 1'b0) begin
      n_err++; $display("FAIL mid_post_busy: got %0h/%0h want 0/0", bus.BusyRs1, bus.BusyRs2); end
    n_cmp++; if (bus.LLReady !== 1'b1) begin n_err++; $display("FAIL mid_post_ready: got %0h want 1", bus.LLReady); end
    tick();
    n_cmp++; if (bus.RfWE !== 1'b0) begin n_err++; $display("FAIL mid_stale_we: got %0h want 0", bus.RfWE); end
    clear_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_w_traffic();
    test_idle_drain();
    test_back_to_back();
    test_starvation();
    test_collision();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_wb_port_arbiter
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter and scoreboard for the single register-file write port at the pipeline writeback stage. In-order writebacks from the W stage always take the port. Results returned by a long-latency execution unit (iterative mul/div) are buffered and written in cycles where W does not write. A per-register busy scoreboard lets the hazard unit stall D-stage readers of in-flight long-latency destinations, and a starvation counter requests a pipeline bubble when buffered results wait too long.

## Interface
Parameters:
- DEPTH, 2: long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4: consecutive blocked cycles before a bubble is requested (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- RegWriteW  in  1  W-stage write enable
- RdW  in  5  W-stage destination register
- ResultW  in  32  W-stage result (from the result mux)
- LLIssue  in  1  long-latency op issued this cycle
- LLIssueRd  in  5  its destination register
- LLValid  in  1  long-latency result valid
- LLRd  in  5  result destination
- LLResult  in  32  result data
- LLReady  out  1  buffer can accept a result
- Rs1D, Rs2D  in  5 each  D-stage source registers
- BusyRs1, BusyRs2  out  1 each  source has a pending long-latency write
- BubbleReq  out  1  ask hazard unit to inject a W-stage bubble
- RfWE  out  1  register-file write enable
- RfA3  out  5  register-file write address
- RfWD  out  32  register-file write data

## Operation
- A W write is active when RegWriteW=1 and RdW≠0. When active: RfWE=1, RfA3=RdW, RfWD=ResultW. There is no buffering or delay.
- Buffer drain: when no W write is active and the buffer is non-empty, RfWE=1 and RfA3/RfWD come from the buffer head. The head pops at the clock edge. Otherwise RfWE=0, and RfA3/RfWD are 0.
- Accept: a result is accepted when LLValid=1 and LLReady=1. LLReady = !full && !reset.
  - Full is based on the registered count. A simultaneous pop does not raise LLReady in the same cycle.
  - A result with LLRd=0 is accepted and discarded; it is not enqueued.
- Scoreboard: busy[31:1] bits; x0 is never busy.
  - LLIssue with LLIssueRd≠0 sets busy[LLIssueRd] at the edge.
  - A drain clears busy[head.rd] at the edge.
  - An accepted LLRd=0 result clears nothing.
  - Set and clear of the same register in the same cycle: set wins.
- BusyRs1 = busy[Rs1D] and BusyRs2 = busy[Rs2D], both combinational from registered state. The bit still reads 1 during the drain cycle (one conservative stall cycle).
- Starvation counter cnt, 0..STARVE_LIMIT:
  - Reset to 0 when the buffer is empty or a drain occurs.
  - Otherwise increments each cycle, saturating at STARVE_LIMIT.
  - BubbleReq = (cnt == STARVE_LIMIT). It is held until a drain occurs.
- Precondition enforced by the hazard unit: no W write targets a busy register. The arbiter does not check this.

## Timing
- Reset (held for one or more cycles): buffer empty, busy all 0, cnt 0.
  - While reset=1: RfWE=0, LLReady=0, BubbleReq=0, BusyRs*=0.
  - Reset mid-operation drops buffered results without writing them.
- W path: zero latency, combinational from RegWriteW/RdW/ResultW.
- LL path: minimum one cycle from acceptance to RfWE (no bypass). Writes occur in FIFO order.
- Busy: a bit set by LLIssue at edge N reads 1 from cycle N+1 and clears on the edge ending its drain cycle.
- With W writing continuously and the buffer non-empty, BubbleReq rises STARVE_LIMIT cycles after the first blocked cycle.

## Structure
- Package wb_pkg:
  - XLEN=32 and REGW=5
  - typedef ll_entry_t {logic [REGW-1:0] rd; logic [XLEN-1:0] data;}
- Sub-module wb_fifo: synchronous FIFO of ll_entry_t with parameter DEPTH. It provides push, pop, head, full and empty outputs, plus a pointer-based count that handles wrap-around.
- The arbiter holds the scoreboard, starvation counter and output muxing.

## Test plan
- Pure W traffic: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF → same-cycle RfWE=1, RfA3=5, RfWD=0xDEADBEEF. With RdW=0 → RfWE=0.
- Idle drain: LLIssue rd=7, then LLValid rd=7 data=0x1234 with W idle.
  - Next cycle RfWE=1, RfA3=7, RfWD=0x1234.
  - BusyRs1 (Rs1D=7) is 1 from the issue+1 cycle through the drain cycle, and 0 after.
- Full and back-pressure: W writing every cycle, 3 LL results offered.
  - LLReady drops after 2 accepts.
  - When W idles, entries drain in order, and LLReady returns the cycle after the first pop.
- Starvation: buffer holds 1 entry while W writes every cycle.
  - BubbleReq=1 on the 5th blocked cycle (STARVE_LIMIT=4).
  - It stays 1 until the first W-idle cycle drains the entry, then is 0.
- Scoreboard collision: drain of rd=9 and LLIssue rd=9 in the same cycle → busy[9] remains 1. LLValid rd=0 → no write and no busy change.
- Reset mid-operation: 2 entries buffered and busy[3]=1, then reset for 1 cycle → RfWE=0 and LLReady=0 during reset. Afterwards the buffer is empty, BusyRs*=0, and nothing stale is written.
